comp_thresh_serial_loader: RTL and testbench



---
 rtl/comp_thresh_serial_loader.sv | 152 +++++++++++++++
 tb/tb_comp_thresh_serial_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/comp_thresh_serial_loader.sv
// Serial loader for daisy-chained comparator-threshold DACs: captures a parallel image on START, shifts it out, strobes LOAD.
// Latency START-sampled edge to SET_DONE rising is NCHAN*NBITS + LOAD_W + 1 edges; START is ignored while busy (no backpressure).
module comp_thresh_serial_loader #(
  parameter int NBITS     = 16,
  parameter int NCHAN     = 1,
  parameter int LOAD_W    = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [NCHAN*NBITS-1:0] DATA,
  output logic                   SDATA,
  output logic                   SHFT_ENA,
  output logic                   LOAD,
  output logic                   BUSY,
  output logic                   SET_DONE
);

  localparam int TOTAL  = NCHAN * NBITS;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int LCNT_W = $clog2(LOAD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLOAD = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TOTAL-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LCNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic                sdata_q, sdata_d;
  logic                shft_ena_q, shft_ena_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                set_done_q, set_done_d;
  logic [TOTAL-1:0]    img;

  // The shift register always emits its MSB; for LSB-first words the bits
  // are mirrored within each word at capture so word order is unchanged.
  always_comb begin
    img = DATA;
    if (LSB_FIRST != 0) begin
      for (int k = 0; k < NCHAN; k++) begin
        for (int b = 0; b < NBITS; b++) begin
          img[k*NBITS + b] = DATA[k*NBITS + NBITS - 1 - b];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    load_cnt_d = load_cnt_q;
    sdata_d    = 1'b0;
    shft_ena_d = 1'b0;
    load_d     = 1'b0;
    busy_d     = 1'b0;
    set_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_PLOAD;
          shreg_d   = img;
          bit_cnt_d = CNT_W'(TOTAL);
          busy_d    = 1'b1;
        end
      end

      S_PLOAD, S_SHIFT: begin
        busy_d = 1'b1;
        if (bit_cnt_q != '0) begin
          state_d    = S_SHIFT;
          sdata_d    = shreg_q[TOTAL-1];
          shft_ena_d = 1'b1;
          shreg_d    = {shreg_q[TOTAL-2:0], 1'b0};
          bit_cnt_d  = bit_cnt_q - CNT_W'(1);
        end else begin
          state_d    = S_LATCH;
          load_d     = 1'b1;
          load_cnt_d = LCNT_W'(LOAD_W);
        end
      end

      // load_cnt holds the strobe cycles still owed, including the current one
      S_LATCH: begin
        if (load_cnt_q > LCNT_W'(1)) begin
          load_d     = 1'b1;
          busy_d     = 1'b1;
          load_cnt_d = load_cnt_q - LCNT_W'(1);
        end else begin
          state_d    = S_DONE;
          set_done_d = 1'b1;
          load_cnt_d = '0;
        end
      end

      S_DONE: begin
        if (START) begin
          set_done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        shreg_d    = '0;
        bit_cnt_d  = '0;
        load_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      sdata_q    <= 1'b0;
      shft_ena_q <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      set_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      load_cnt_q <= load_cnt_d;
      sdata_q    <= sdata_d;
      shft_ena_q <= shft_ena_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      set_done_q <= set_done_d;
    end
  end

  assign SDATA    = sdata_q;
  assign SHFT_ENA = shft_ena_q;
  assign LOAD     = load_q;
  assign BUSY     = busy_q;
  assign SET_DONE = set_done_q;

endmodule

// File: tb/tb_comp_thresh_serial_loader.sv
// Bench for comp_thresh_serial_loader: three instances (MSB-first 2x4, LSB-first 2x4, default 1x16)
// checked every cycle against per-edge expectations queued when stimulus is driven.
module tb_comp_thresh_serial_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_ab;
  logic        start_c;
  logic [7:0]  data_ab;
  logic [15:0] data_c;

  logic sd_a, sh_a, ld_a, bz_a, dn_a;
  logic sd_b, sh_b, ld_b, bz_b, dn_b;
  logic sd_c, sh_c, ld_c, bz_c, dn_c;

  always #5 clk = ~clk;

  comp_thresh_serial_loader #(.NBITS(4), .NCHAN(2), .LOAD_W(2), .LSB_FIRST(0)) dut_a (
    .CLK(clk), .RST(rst), .START(start_ab), .DATA(data_ab),
    .SDATA(sd_a), .SHFT_ENA(sh_a), .LOAD(ld_a), .BUSY(bz_a), .SET_DONE(dn_a)
  );

  comp_thresh_serial_loader #(.NBITS(4), .NCHAN(2), .LOAD_W(2), .LSB_FIRST(1)) dut_b (
    .CLK(clk), .RST(rst), .START(start_ab), .DATA(data_ab),
    .SDATA(sd_b), .SHFT_ENA(sh_b), .LOAD(ld_b), .BUSY(bz_b), .SET_DONE(dn_b)
  );

  comp_thresh_serial_loader dut_c (
    .CLK(clk), .RST(rst), .START(start_c), .DATA(data_c),
    .SDATA(sd_c), .SHFT_ENA(sh_c), .LOAD(ld_c), .BUSY(bz_c), .SET_DONE(dn_c)
  );

  // Expected bits are {SDATA, SHFT_ENA, LOAD, BUSY, SET_DONE} after one edge.
  typedef struct {
    string      tag;
    int         idx;
    logic [4:0] bits;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] data;
    int         start_len;
    int         chg_at;
    logic [7:0] chg_data;
    int         rst_at;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  vec_t vecs[6];

  int n_chk  = 0;
  int n_pass = 0;

  // Edge i counts from E0, the edge that samples START high in Idle.
  function automatic logic [4:0] exp_at(input int i, input int t, input int lw,
                                        input int slen, input int rst_at,
                                        input logic [15:0] stream);
    logic sd, sh, ld, bz, dn;
    int   d_edge, d_last;
    if (rst_at >= 0 && i >= rst_at) return 5'b0;
    d_edge = t + lw + 1;
    d_last = (slen - 1 > d_edge) ? slen - 1 : d_edge;
    sh = (i >= 1) && (i <= t);
    sd = sh ? stream[t - i] : 1'b0;
    ld = (i > t) && (i <= t + lw);
    bz = (i >= 0) && (i <= t + lw);
    dn = (i >= d_edge) && (i <= d_last);
    return {sd, sh, ld, bz, dn};
  endfunction

  function automatic exp_t mk(input string tag, input int idx, input logic [4:0] bits);
    exp_t e;
    e.tag  = tag;
    e.idx  = idx;
    e.bits = bits;
    return e;
  endfunction

  task automatic chk(input string dut, input exp_t e, input logic [4:0] got);
    n_chk++;
    if (got === e.bits) begin
      n_pass++;
    end else begin
      $display("FAIL %s dut_%s edge %0d: got {sdata,shft,load,busy,done}=%b, expected %b",
               e.tag, dut, e.idx, got, e.bits);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("a", e, {sd_a, sh_a, ld_a, bz_a, dn_a});
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("b", e, {sd_b, sh_b, ld_b, bz_b, dn_b});
    end
    if (q_c.size() > 0) begin
      e = q_c.pop_front();
      chk("c", e, {sd_c, sh_c, ld_c, bz_c, dn_c});
    end
  end

  task automatic idle_cycles(input string tag, input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rst      = r;
      start_ab = 1'b0;
      start_c  = 1'b0;
      q_a.push_back(mk(tag, i, 5'b0));
      q_b.push_back(mk(tag, i, 5'b0));
      q_c.push_back(mk(tag, i, 5'b0));
    end
  endtask

  task automatic run_ab(input vec_t v);
    int n;
    n = ((v.start_len > 11) ? v.start_len : 11) + 2;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      #1;
      start_ab = (i < v.start_len);
      start_c  = 1'b0;
      rst      = (i == v.rst_at);
      data_ab  = (v.chg_at >= 0 && i >= v.chg_at) ? v.chg_data : v.data;
      q_a.push_back(mk(v.name, i, exp_at(i, 8, 2, v.start_len, v.rst_at, {8'h00, v.exp_msb})));
      q_b.push_back(mk(v.name, i, exp_at(i, 8, 2, v.start_len, v.rst_at, {8'h00, v.exp_lsb})));
      q_c.push_back(mk(v.name, i, 5'b0));
    end
  endtask

  task automatic run_c(input string name, input logic [15:0] d, input int slen,
                       input logic [15:0] stream);
    int n;
    n = ((slen > 19) ? slen : 19) + 2;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      #1;
      start_ab = 1'b0;
      start_c  = (i < slen);
      rst      = 1'b0;
      data_c   = (i == 0) ? d : ~d;
      q_a.push_back(mk(name, i, 5'b0));
      q_b.push_back(mk(name, i, 5'b0));
      q_c.push_back(mk(name, i, exp_at(i, 16, 2, slen, -1, stream)));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start_ab = 1'b0;
    start_c  = 1'b0;
    data_ab  = 8'h00;
    data_c   = 16'h0000;

    // Expected serial streams are written first bit in the MSB position.
    vecs[0] = '{"basic",      8'hA5, 1,  -1, 8'h00, -1, 8'hA5, 8'h5A};
    vecs[1] = '{"start_held", 8'hA5, 20, -1, 8'h00, -1, 8'hA5, 8'h5A};
    vecs[2] = '{"data_chg",   8'hA5, 3,  3,  8'hFF, -1, 8'hA5, 8'h5A};
    vecs[3] = '{"rst_mid",    8'hA5, 1,  -1, 8'h00, 4,  8'hA5, 8'h5A};
    vecs[4] = '{"after_rst",  8'h3C, 1,  -1, 8'h00, -1, 8'h3C, 8'hC3};
    vecs[5] = '{"pat_81",     8'h81, 2,  -1, 8'h00, -1, 8'h81, 8'h18};

    idle_cycles("reset", 2, 1'b1);
    idle_cycles("idle", 2, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_ab(vecs[k]);
    end

    run_c("wide_8001", 16'h8001, 1, 16'h8001);
    run_c("wide_c350_held", 16'hC350, 23, 16'hC350);

    idle_cycles("tail", 2, 1'b0);
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
